// File: rtl/usb_rx_sipo_assembler_if.sv
// Bundle between the USB RX front end / packet FSM and the SIPO word assembler.
// Handshake: byte_valid marks rx_byte as holding an unconsumed word; a word is
// consumed on any rising clk edge where byte_valid and byte_ready are both 1.
// rx_byte is held stable while byte_valid is 1. The producer never waits on
// byte_ready before raising byte_valid.
interface usb_rx_sipo_assembler_if #(
   parameter int NUM_BITS = 8
);
   logic                shift_enable;
   logic                serial_in;
   logic                stuff_bit;
   logic                sync_clear;
   logic                eop;
   logic                byte_ready;
   logic [NUM_BITS-1:0] rx_byte;
   logic                byte_valid;
   logic                overrun;
   logic                partial_err;
   logic                stuff_err;

   // Front end / consumer side
   modport master (
      output shift_enable, serial_in, stuff_bit, sync_clear, eop, byte_ready,
      input  rx_byte, byte_valid, overrun, partial_err, stuff_err
   );

   // Assembler side
   modport slave (
      input  shift_enable, serial_in, stuff_bit, sync_clear, eop, byte_ready,
      output rx_byte, byte_valid, overrun, partial_err, stuff_err
   );
endinterface

// File: rtl/usb_rx_sipo_assembler.sv
// USB RX serial-in/parallel-out word assembler.
// Drops stuffed bits, packs data bits into NUM_BITS-wide words (LSB-first when
// SHIFT_MSB=0, MSB-first when SHIFT_MSB=1) and offers each word on a
// valid/ready handshake. Flags overrun and truncated words.
// Optional: define RX_STUFF_CHECK_EN to flag stuffed bits that are not 0.
// dbg_state exposes the FSM state (1 = ACTIVE, 0 = IDLE).
module usb_rx_sipo_assembler #(
   parameter int NUM_BITS  = 8,
   parameter int SHIFT_MSB = 0
) (
   input  logic                      clk,
   input  logic                      n_rst,
   usb_rx_sipo_assembler_if.slave    bus,
   output logic                      dbg_state
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam int            CW   = $clog2(NUM_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

   state_t              state, state_nxt;
   logic [NUM_BITS-1:0] sr, sr_nxt, sr_shifted;
   logic [NUM_BITS-1:0] rx_q, rx_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                bv_q, bv_nxt;
   logic                ov_q, ov_nxt;
   logic                pe_q, pe_nxt;
   logic                data_bit;
   logic                word_done;

   // The shifted value already contains the current bit, so it is also the
   // completed word when this is the last bit of a word.
   assign sr_shifted = (SHIFT_MSB != 0) ? {sr[NUM_BITS-2:0], bus.serial_in}
                                        : {bus.serial_in, sr[NUM_BITS-1:1]};
   assign data_bit   = (state == ACTIVE) && bus.shift_enable && !bus.stuff_bit;
   assign word_done  = data_bit && (cnt == LAST);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and datapath: sync_clear beats eop beats shift; the
   // handshake runs independently so a pending word survives sync_clear.
   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      rx_nxt    = rx_q;
      bv_nxt    = bv_q;
      ov_nxt    = ov_q;
      pe_nxt    = pe_q;
      if (bv_q && bus.byte_ready) bv_nxt = 1'b0;
      if (bus.sync_clear) begin
         state_nxt = ACTIVE;
         cnt_nxt   = '0;
         sr_nxt    = '0;
         ov_nxt    = 1'b0;
         pe_nxt    = 1'b0;
      end else if (state == ACTIVE) begin
         if (data_bit) begin
            sr_nxt = sr_shifted;
            if (word_done) begin
               cnt_nxt = '0;
               if (!bv_q || bus.byte_ready) begin
                  rx_nxt = sr_shifted;
                  bv_nxt = 1'b1;
               end else begin
                  ov_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         if (bus.eop) begin
            state_nxt = IDLE;
            sr_nxt    = '0;
            if (cnt_nxt != '0) pe_nxt = 1'b1;
         end
      end
   end

   // Datapath and status registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr   <= '0;
         cnt  <= '0;
         rx_q <= '0;
         bv_q <= 1'b0;
         ov_q <= 1'b0;
         pe_q <= 1'b0;
      end else begin
         sr   <= sr_nxt;
         cnt  <= cnt_nxt;
         rx_q <= rx_nxt;
         bv_q <= bv_nxt;
         ov_q <= ov_nxt;
         pe_q <= pe_nxt;
      end
   end

`ifdef RX_STUFF_CHECK_EN
   logic se_q;

   // A stuffed bit must be 0; a 1 here is a stuffing violation (sticky).
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                                  se_q <= 1'b0;
      else if (bus.sync_clear)                     se_q <= 1'b0;
      else if ((state == ACTIVE) && bus.shift_enable && bus.stuff_bit && bus.serial_in)
                                                   se_q <= 1'b1;
   end

   assign bus.stuff_err = se_q;
`else
   assign bus.stuff_err = 1'b0;
`endif

   assign bus.rx_byte     = rx_q;
   assign bus.byte_valid  = bv_q;
   assign bus.overrun     = ov_q;
   assign bus.partial_err = pe_q;
   assign dbg_state       = (state == ACTIVE);

endmodule

// File: tb/tb_usb_rx_sipo_assembler.sv
// Bench for usb_rx_sipo_assembler: directed scenarios plus randomized packets
// scored against a word-level model (LSB-first and bit-reversed MSB-first).
module tb_usb_rx_sipo_assembler;

`ifdef RX_STUFF_CHECK_EN
   localparam logic STUFF_EXP = 1'b1;
`else
   localparam logic STUFF_EXP = 1'b0;
`endif

   logic clk;
   logic n_rst;
   logic dbg_state;
   logic dbg_state2;
   int   checks;
   int   failures;
   logic mon_en;
   logic [7:0] exp_q[$];
   logic [7:0] exp2_q[$];

   usb_rx_sipo_assembler_if #(.NUM_BITS(8)) bus ();
   usb_rx_sipo_assembler_if #(.NUM_BITS(8)) bus2 ();

   assign bus2.shift_enable = bus.shift_enable;
   assign bus2.serial_in    = bus.serial_in;
   assign bus2.stuff_bit    = bus.stuff_bit;
   assign bus2.sync_clear   = bus.sync_clear;
   assign bus2.eop          = bus.eop;
   assign bus2.byte_ready   = bus.byte_ready;

   usb_rx_sipo_assembler #(.NUM_BITS(8), .SHIFT_MSB(0)) dut (
      .clk(clk), .n_rst(n_rst), .bus(bus), .dbg_state(dbg_state)
   );

   usb_rx_sipo_assembler #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_msb (
      .clk(clk), .n_rst(n_rst), .bus(bus2), .dbg_state(dbg_state2)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every consumed word must match the head of the expected queue
   always @(negedge clk) begin
      if (mon_en && bus.byte_valid && bus.byte_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_lsb_unexpected got=%h exp=none", bus.rx_byte);
         end else if (bus.rx_byte !== exp_q[0]) begin
            failures++;
            $display("FAIL sb_lsb_word got=%h exp=%h", bus.rx_byte, exp_q[0]);
            void'(exp_q.pop_front());
         end else begin
            void'(exp_q.pop_front());
         end
      end
      if (mon_en && bus2.byte_valid && bus2.byte_ready) begin
         checks++;
         if (exp2_q.size() == 0) begin
            failures++;
            $display("FAIL sb_msb_unexpected got=%h exp=none", bus2.rx_byte);
         end else if (bus2.rx_byte !== exp2_q[0]) begin
            failures++;
            $display("FAIL sb_msb_word got=%h exp=%h", bus2.rx_byte, exp2_q[0]);
            void'(exp2_q.pop_front());
         end else begin
            void'(exp2_q.pop_front());
         end
      end
   end

   // Driver tasks: all start and end on a falling edge
   task automatic send_bit(input logic b, input logic st, input int gap);
      repeat (gap) @(negedge clk);
      bus.shift_enable = 1'b1;
      bus.serial_in    = b;
      bus.stuff_bit    = st;
      @(negedge clk);
      bus.shift_enable = 1'b0;
      bus.stuff_bit    = 1'b0;
      bus.serial_in    = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0, gap);
   endtask

   task automatic pulse_sync();
      bus.sync_clear = 1'b1;
      @(negedge clk);
      bus.sync_clear = 1'b0;
   endtask

   task automatic pulse_eop();
      bus.eop = 1'b1;
      @(negedge clk);
      bus.eop = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", bus.rx_byte); end
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", bus.byte_valid); end
      checks++; if ({bus.overrun, bus.partial_err, bus.stuff_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.overrun, bus.partial_err, bus.stuff_err}); end
      checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
      n_rst = 1'b1;
      @(negedge clk);
      // shift strobes in IDLE are ignored
      send_word(8'hFF, 0);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL idle_ignore got=%b exp=0", bus.byte_valid); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] pat;
      pat = 8'b1010_0101;
      bus.byte_ready = 1'b1;
      pulse_sync();
      for (int i = 0; i < 7; i++) send_bit(pat[i], 1'b0, 3);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL lsb_early_valid got=%b exp=0", bus.byte_valid); end
      send_bit(pat[7], 1'b0, 3);
      checks++; if (bus.byte_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", bus.byte_valid); end
      checks++; if (bus.rx_byte !== 8'hA5) begin failures++; $display("FAIL lsb_word got=%h exp=a5", bus.rx_byte); end
      @(negedge clk);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL lsb_valid_len got=%b exp=0", bus.byte_valid); end
   endtask

   task automatic test_stuffed();
      bus.byte_ready = 1'b1;
      pulse_sync();
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1);
      send_bit(1'b0, 1'b1, 1);
      send_bit(1'b1, 1'b0, 1);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL stuff_counted got=%b exp=0", bus.byte_valid); end
      send_bit(1'b1, 1'b0, 1);
      checks++; if (bus.byte_valid !== 1'b1 || bus.rx_byte !== 8'hFF) begin failures++; $display("FAIL stuff_word got=%b/%h exp=1/ff", bus.byte_valid, bus.rx_byte); end
      checks++; if (bus.stuff_err !== 1'b0) begin failures++; $display("FAIL stuff_err_clean got=%b exp=0", bus.stuff_err); end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      bus.byte_ready = 1'b0;
      pulse_sync();
      send_word(8'h3C, 1);
      checks++; if (bus.byte_valid !== 1'b1 || bus.rx_byte !== 8'h3C) begin failures++; $display("FAIL ovr_first got=%b/%h exp=1/3c", bus.byte_valid, bus.rx_byte); end
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", bus.overrun); end
      send_word(8'hC3, 1);
      checks++; if (bus.rx_byte !== 8'h3C) begin failures++; $display("FAIL ovr_kept got=%h exp=3c", bus.rx_byte); end
      checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
      bus.byte_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", bus.byte_valid); end
      checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
      pulse_sync();
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
   endtask

   task automatic test_truncated();
      bus.byte_ready = 1'b1;
      pulse_sync();
      send_bit(1'b1, 1'b0, 0);
      send_bit(1'b0, 1'b0, 2);
      send_bit(1'b1, 1'b0, 1);
      pulse_eop();
      checks++; if (bus.partial_err !== 1'b1) begin failures++; $display("FAIL trunc_perr got=%b exp=1", bus.partial_err); end
      checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL trunc_state got=%b exp=0", dbg_state); end
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL trunc_valid got=%b exp=0", bus.byte_valid); end
      send_word(8'h5A, 0);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL trunc_ignore got=%b exp=0", bus.byte_valid); end
      pulse_sync();
      checks++; if (bus.partial_err !== 1'b0) begin failures++; $display("FAIL trunc_clear got=%b exp=0", bus.partial_err); end
      // whole words followed by eop leave no partial error
      send_word(8'h11, 0);
      pulse_eop();
      checks++; if (bus.partial_err !== 1'b0) begin failures++; $display("FAIL full_eop_perr got=%b exp=0", bus.partial_err); end
   endtask

   task automatic test_reset_mid_word();
      bus.byte_ready = 1'b0;
      pulse_sync();
      send_word(8'h77, 0);
      send_word(8'h88, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1);
      checks++; if (bus.overrun !== 1'b1 || bus.byte_valid !== 1'b1) begin failures++; $display("FAIL rst_setup got=%b%b exp=11", bus.overrun, bus.byte_valid); end
      #2 n_rst = 1'b0;
      #1;
      checks++; if ({bus.byte_valid, bus.overrun, bus.partial_err, bus.stuff_err} !== 4'b0000) begin failures++; $display("FAIL rst_async_flags got=%b exp=0000", {bus.byte_valid, bus.overrun, bus.partial_err, bus.stuff_err}); end
      checks++; if (bus.rx_byte !== 8'h00 || dbg_state !== 1'b0) begin failures++; $display("FAIL rst_async_word got=%h/%b exp=00/0", bus.rx_byte, dbg_state); end
      #1 n_rst = 1'b1;
      @(negedge clk);
      bus.byte_ready = 1'b1;
      pulse_sync();
      send_word(8'h5A, 2);
      checks++; if (bus.byte_valid !== 1'b1 || bus.rx_byte !== 8'h5A) begin failures++; $display("FAIL rst_recover got=%b/%h exp=1/5a", bus.byte_valid, bus.rx_byte); end
      @(negedge clk);
   endtask

   task automatic test_stuff_check();
      logic [7:0] w;
      w = 8'h96;
      bus.byte_ready = 1'b1;
      pulse_sync();
      for (int i = 0; i < 3; i++) send_bit(w[i], 1'b0, 1);
      send_bit(1'b1, 1'b1, 1);
      checks++; if (bus.stuff_err !== STUFF_EXP) begin failures++; $display("FAIL stuffchk_flag got=%b exp=%b", bus.stuff_err, STUFF_EXP); end
      for (int i = 3; i < 8; i++) send_bit(w[i], 1'b0, 1);
      checks++; if (bus.byte_valid !== 1'b1 || bus.rx_byte !== 8'h96) begin failures++; $display("FAIL stuffchk_word got=%b/%h exp=1/96", bus.byte_valid, bus.rx_byte); end
      checks++; if (bus.stuff_err !== STUFF_EXP) begin failures++; $display("FAIL stuffchk_sticky got=%b exp=%b", bus.stuff_err, STUFF_EXP); end
      pulse_sync();
      checks++; if (bus.stuff_err !== 1'b0) begin failures++; $display("FAIL stuffchk_clear got=%b exp=0", bus.stuff_err); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      w = 8'h34;
      bus.byte_ready = 1'b0;
      pulse_sync();
      send_word(8'h12, 0);
      checks++; if (bus.rx_byte !== 8'h12 || bus2.rx_byte !== 8'h48) begin failures++; $display("FAIL b2b_first got=%h/%h exp=12/48", bus.rx_byte, bus2.rx_byte); end
      for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0, 0);
      // consumer accepts in the same cycle the next word completes
      bus.shift_enable = 1'b1;
      bus.serial_in    = w[7];
      bus.byte_ready   = 1'b1;
      @(negedge clk);
      bus.shift_enable = 1'b0;
      checks++; if (bus.rx_byte !== 8'h34 || bus.byte_valid !== 1'b1) begin failures++; $display("FAIL b2b_load got=%h/%b exp=34/1", bus.rx_byte, bus.byte_valid); end
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
      checks++; if (bus2.rx_byte !== 8'h2C) begin failures++; $display("FAIL b2b_msb got=%h exp=2c", bus2.rx_byte); end
      @(negedge clk);
      checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.byte_valid); end
   endtask

   task automatic test_random();
      logic [7:0] w;
      logic [7:0] r;
      int         nw;
      int         gap;
      bus.byte_ready = 1'b1;
      mon_en = 1'b1;
      for (int p = 0; p < 15; p++) begin
         pulse_sync();
         nw = $urandom_range(1, 3);
         gap = $urandom_range(0, 3);
         for (int k = 0; k < nw; k++) begin
            w = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) r[7-i] = w[i];
            exp_q.push_back(w);
            exp2_q.push_back(r);
            for (int i = 0; i < 8; i++) begin
               if ($urandom_range(0, 3) == 0) send_bit(1'b0, 1'b1, gap);
               send_bit(w[i], 1'b0, gap);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            pulse_eop();
            checks++; if (bus.partial_err !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL rand_eop got=%b/%b exp=0/0", bus.partial_err, dbg_state); end
         end
      end
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      checks++; if (exp_q.size() != 0 || exp2_q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d/%0d exp=0/0", exp_q.size(), exp2_q.size()); end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      mon_en           = 1'b0;
      n_rst            = 1'b0;
      bus.shift_enable = 1'b0;
      bus.serial_in    = 1'b0;
      bus.stuff_bit    = 1'b0;
      bus.sync_clear   = 1'b0;
      bus.eop          = 1'b0;
      bus.byte_ready   = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_lsb_first();
      test_stuffed();
      test_overrun();
      test_truncated();
      test_reset_mid_word();
      test_stuff_check();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb_rx_sipo_assembler.md
Name: usb_rx_sipo_assembler

Overview:
Receive-side counterpart of the TX parallel-to-serial shifter. It takes the decoded, NRZI-removed serial bit stream from the USB RX front end on per-bit strobes and discards stuffed bits. It assembles the remaining bits into NUM_BITS-wide words and hands each word to the RX packet FSM over a valid/ready handshake. It also flags overrun and truncated-word conditions for the RX error logic.

Parameters:
NUM_BITS, 8, width of the assembled word.
SHIFT_MSB, 0. 0: first received bit lands in bit 0 (USB LSB-first). 1: first received bit lands in bit NUM_BITS-1.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
shift_enable  input  1  one-cycle strobe: serial_in holds a valid bit this cycle
serial_in  input  1  decoded receive bit
stuff_bit  input  1  qualifies shift_enable: current bit is a stuffed bit
sync_clear  input  1  one-cycle pulse: SYNC detected, start of packet
eop  input  1  one-cycle pulse: end of packet detected
byte_ready  input  1  consumer accepts rx_byte
rx_byte  output  NUM_BITS  assembled word, registered
byte_valid  output  1  rx_byte holds an unconsumed word
overrun  output  1  sticky: a word completed while the previous word was still pending
partial_err  output  1  sticky: EOP arrived with a partially assembled word
stuff_err  output  1  sticky bit-stuff violation (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low on n_rst.
- Reset values:
  - shift register = 0, bit counter = 0, state = IDLE
  - rx_byte = 0, byte_valid = 0, overrun = 0, partial_err = 0, stuff_err = 0
- Bit counter width: $clog2(NUM_BITS+1).
- FSM states: IDLE and ACTIVE.
- IDLE:
  - shift_enable is ignored.
  - sync_clear -> ACTIVE.
- sync_clear, in either state:
  - next state = ACTIVE; counter = 0; shift register = 0.
  - overrun, partial_err and stuff_err are cleared.
  - byte_valid and rx_byte are untouched, so a pending word is still delivered.
- ACTIVE, shift_enable=1 and stuff_bit=1: bit discarded; counter and shift register unchanged.
- ACTIVE, shift_enable=1 and stuff_bit=0 (data bit):
  - SHIFT_MSB=0: sr <= {serial_in, sr[NUM_BITS-1:1]}.
  - SHIFT_MSB=1: sr <= {sr[NUM_BITS-2:0], serial_in}.
  - counter increments by 1.
- Word completion (data bit arrives while counter == NUM_BITS-1):
  - The assembled word, including the current bit, goes to rx_byte. The counter wraps to 0.
  - byte_valid = 1 from the next cycle (one-cycle latency from the last bit strobe).
- Handshake:
  - byte_valid & byte_ready -> byte_valid = 0 next cycle.
  - rx_byte stays stable while byte_valid = 1.
- Word completion while byte_valid = 1:
  - With byte_ready = 1 in the same cycle: the new word loads, byte_valid stays 1, no overrun.
  - With byte_ready = 0: the new word is dropped, the old word is kept, overrun = 1.
- eop in ACTIVE: next state = IDLE.
  - If the post-shift counter != 0 (any same-cycle shift is applied first): partial_err = 1.
  - The shift register is cleared. The partial word is never presented.
- Priority for same-cycle events: sync_clear > eop > shift.
- eop in IDLE: no effect.
- Reset asserted mid-word or mid-handshake: all state returns to reset values immediately.

Optional Feature:
Macro RX_STUFF_CHECK_EN.
- Defined: in ACTIVE, shift_enable & stuff_bit & serial_in = 1 (a stuffed bit must be 0) sets stuff_err. stuff_err stays set until sync_clear or reset. The bit is still discarded.
- Undefined: the check logic is not compiled. stuff_err is tied to 0.

Test Plan:
- LSB-first assembly: SHIFT_MSB=0. sync_clear, then data bits 1,0,1,0,0,1,0,1 (one strobe every 4 cycles), byte_ready=1 -> rx_byte=0xA5; byte_valid high for exactly 1 cycle, starting the cycle after the 8th strobe.
- Stuffed-bit removal: 0xFF sent as six 1s, a stuffed 0 (stuff_bit=1), then two 1s -> one word 0xFF; the stuffed strobe does not advance the counter; stuff_err=0.
- Backpressure and overrun: byte_ready=0, send 0x3C then 0xC3 -> rx_byte stays 0x3C, overrun=1. Raise byte_ready -> byte_valid falls. Next sync_clear -> overrun=0.
- Truncated packet: sync_clear, 3 data bits, eop -> partial_err=1, state IDLE, byte_valid=0. Later shift strobes are ignored until the next sync_clear.
- Reset mid-word: 5 data bits, then pulse n_rst low between clock edges -> all outputs 0 immediately. After sync_clear, a full 0x5A assembles correctly.
- RX_STUFF_CHECK_EN defined: a stuffed strobe with serial_in=1 -> stuff_err=1 and no counter change. With the macro undefined, the same stimulus leaves stuff_err=0.
